// File: rtl/vga_anim_pkg.sv
// rtl/vga_anim_pkg.sv - shared mode encodings and default sizes for the VGA animation sequencer
package vga_anim_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STOP = 2'b00;
  localparam mode_t MODE_RUN  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;
  localparam mode_t MODE_AUTO = 2'b11;

  localparam int DEF_OFFSET_W     = 10;
  localparam int DEF_SPEED_W      = 4;
  localparam int DEF_HOLD_FRAMES  = 60;
  localparam int DEF_NUM_PATTERNS = 4;

endpackage

// File: rtl/vga_anim_sequencer_if.sv
// rtl/vga_anim_sequencer_if.sv - vsync, config handshake and pattern control bundle
interface vga_anim_sequencer_if
  import vga_anim_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int SPEED_W  = DEF_SPEED_W
) ();

  logic                vsync;
  logic                cfg_valid;
  logic                cfg_ready;
  mode_t               cfg_mode;
  logic [SPEED_W-1:0]  cfg_speed;
  logic                cfg_dir;
  logic                step_req;
  logic                frame_tick;
  logic [OFFSET_W-1:0] x_offset;
  logic [1:0]          pattern_sel;
  mode_t               mode_active;

  modport master (
    output vsync, cfg_valid, cfg_mode, cfg_speed, cfg_dir, step_req,
    input  cfg_ready, frame_tick, x_offset, pattern_sel, mode_active
  );

  modport slave (
    input  vsync, cfg_valid, cfg_mode, cfg_speed, cfg_dir, step_req,
    output cfg_ready, frame_tick, x_offset, pattern_sel, mode_active
  );

endinterface

// File: rtl/vga_frame_tick.sv
// rtl/vga_frame_tick.sv - vsync resampler producing a one-cycle pulse per rising edge
module vga_frame_tick (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_frame_tick
);

  logic r_vs_q1;
  logic r_vs_q2;

  // Both stages reset high so a vsync already high at release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_q1 <= 1'b1;
      r_vs_q2 <= 1'b1;
    end else begin
      r_vs_q1 <= i_vsync;
      r_vs_q2 <= r_vs_q1;
    end
  end

  assign o_frame_tick = r_vs_q1 & ~r_vs_q2;

endmodule

// File: rtl/vga_anim_sequencer.sv
// rtl/vga_anim_sequencer.sv - frame-locked scroll/pattern controller with double-buffered config
module vga_anim_sequencer
  import vga_anim_pkg::*;
#(
  parameter int OFFSET_W     = DEF_OFFSET_W,
  parameter int SPEED_W      = DEF_SPEED_W,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int NUM_PATTERNS = DEF_NUM_PATTERNS
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_anim_sequencer_if.slave  bus
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic                r_pend_full;
  mode_t               r_pend_mode;
  logic [SPEED_W-1:0]  r_pend_speed;
  logic                r_pend_dir;
  mode_t               r_mode;
  logic [SPEED_W-1:0]  r_speed;
  logic                r_dir;
  logic                r_step_pend;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [1:0]          r_pattern;
  logic [OFFSET_W-1:0] r_offset;

  logic                w_tick;
  logic                w_accept;
  logic                w_apply;
  mode_t               w_next_mode;
  logic                w_move;
  logic [OFFSET_W-1:0] w_moved_off;
  logic                w_hold_wrap;

  vga_frame_tick u_frame_tick (
    .clk          (clk),
    .reset        (reset),
    .i_vsync      (bus.vsync),
    .o_frame_tick (w_tick)
  );

  assign w_accept    = bus.cfg_valid & ~r_pend_full;
  assign w_apply     = w_tick & r_pend_full;
  assign w_next_mode = w_apply ? r_pend_mode : r_mode;
  assign w_hold_wrap = (r_hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
  assign w_moved_off = r_dir ? (r_offset - OFFSET_W'(r_speed)) : (r_offset + OFFSET_W'(r_speed));

  // Movement always uses the config active before any apply in the same cycle.
  always_comb begin
    w_move = 1'b0;
    case (r_mode)
      MODE_RUN, MODE_AUTO: w_move = w_tick;
      MODE_STEP:           w_move = w_tick & r_step_pend;
      default:             w_move = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_full  <= 1'b0;
      r_pend_mode  <= MODE_STOP;
      r_pend_speed <= '0;
      r_pend_dir   <= 1'b0;
      r_mode       <= MODE_STOP;
      r_speed      <= '0;
      r_dir        <= 1'b0;
    end else if (w_apply) begin
      r_mode      <= r_pend_mode;
      r_speed     <= r_pend_speed;
      r_dir       <= r_pend_dir;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_mode  <= bus.cfg_mode;
      r_pend_speed <= bus.cfg_speed;
      r_pend_dir   <= bus.cfg_dir;
      r_pend_full  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_offset    <= '0;
      r_step_pend <= 1'b0;
      r_hold_cnt  <= '0;
      r_pattern   <= 2'd0;
    end else begin
      if (w_move) r_offset <= w_moved_off;

      // A request arriving while one is pending is absorbed: at most one step per frame.
      if (w_next_mode != MODE_STEP)
        r_step_pend <= 1'b0;
      else if (w_tick && r_step_pend && r_mode == MODE_STEP)
        r_step_pend <= 1'b0;
      else if (bus.step_req && r_mode == MODE_STEP)
        r_step_pend <= 1'b1;

      if (w_tick && r_mode == MODE_AUTO) begin
        if (w_hold_wrap) begin
          r_hold_cnt <= '0;
          r_pattern  <= (r_pattern == 2'(NUM_PATTERNS - 1)) ? 2'd0 : r_pattern + 2'd1;
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
      if (w_apply && r_pend_mode == MODE_AUTO && r_mode != MODE_AUTO)
        r_hold_cnt <= '0;
    end
  end

  assign bus.cfg_ready   = ~r_pend_full;
  assign bus.frame_tick  = w_tick;
  assign bus.x_offset    = r_offset;
  assign bus.pattern_sel = r_pattern;
  assign bus.mode_active = r_mode;

endmodule

// File: doc/vga_anim_sequencer.md
Name: vga_anim_sequencer

Overview:
Frame-synchronous controller for the animated VGA pattern datapath. It sits beside hvsync_generator and derives a clean single-cycle frame tick from vsync in the pixel-clock domain, with no clocking on vsync. The pattern logic consumes its scroll offset and pattern select. Configuration arrives over a valid/ready port and is double-buffered, so mode, speed and direction change only at frame boundaries and never tear mid-frame.

Parameters:
OFFSET_W, 10, width of x_offset; wraps modulo 2^OFFSET_W
SPEED_W, 4, width of per-frame step size
HOLD_FRAMES, 60, frame ticks per pattern in AUTO mode (>=1)
NUM_PATTERNS, 4, number of patterns cycled in AUTO mode (2..4)

Ports:
clk  in  1  pixel clock (single clock domain)
reset  in  1  asynchronous, active-high reset
vsync  in  1  registered vsync from hvsync_generator
cfg_valid  in  1  config offered
cfg_ready  out  1  pending buffer empty; config can be accepted
cfg_mode  in  2  00 STOP, 01 RUN, 10 STEP, 11 AUTO
cfg_speed  in  SPEED_W  pixels advanced per frame
cfg_dir  in  1  0 = offset increases, 1 = offset decreases
step_req  in  1  single-cycle request for one advance (STEP mode only)
frame_tick  out  1  one-cycle pulse per vsync rising edge
x_offset  out  OFFSET_W  scroll offset for the pattern datapath
pattern_sel  out  2  active pattern index
mode_active  out  2  currently applied mode

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, reset).
- Reset values:
  - vs_q1 = 1 and vs_q2 = 1, so no spurious tick if vsync is high at release.
  - frame_tick = 0, x_offset = 0, pattern_sel = 0, mode_active = STOP.
  - Active speed and dir = 0; pending buffer empty, so cfg_ready = 1.
  - step_pend = 0, hold_cnt = 0.
- Tick generation:
  - vs_q1 <= vsync; vs_q2 <= vs_q1.
  - frame_tick = vs_q1 & ~vs_q2, decoded from flops only.
  - frame_tick is high exactly one cycle per vsync rising edge, 1 cycle after the edge is sampled.
- Config handshake:
  - cfg_ready = ~pend_full.
  - Accept when cfg_valid & cfg_ready: mode, speed and dir are copied to pending and pend_full is set.
  - cfg_valid while not ready is ignored; the source must hold the config.
- Apply:
  - On the frame_tick cycle with pend_full, the active config takes pending and pend_full is cleared.
  - cfg_ready rises on the following cycle.
  - A config accepted in the same cycle as frame_tick is not applied at that tick; it applies at the next tick.
- Advance at each frame_tick uses the active config from before any apply in that cycle:
  - STOP: x_offset holds.
  - RUN: x_offset += speed if dir = 0, x_offset -= speed if dir = 1, modulo 2^OFFSET_W (natural wrap).
  - STEP: advance as in RUN only if step_pend is set, then clear step_pend.
  - AUTO: advance as in RUN. hold_cnt increments; when hold_cnt == HOLD_FRAMES-1 it returns to 0 and pattern_sel increments, wrapping NUM_PATTERNS-1 -> 0.
  - speed = 0 gives no movement in any mode.
- step_req:
  - Sets step_pend only while the active mode is STEP.
  - Further step_req while pending is absorbed, so at most one step per tick.
  - step_req in the frame_tick cycle with step_pend = 0 sets step_pend; that step applies at the next tick.
  - Leaving STEP clears step_pend.
- Mode change into AUTO clears hold_cnt; pattern_sel keeps its value. Outside AUTO, pattern_sel holds.
- Latency: x_offset, pattern_sel and mode_active update on the clock edge ending the frame_tick cycle.
- Reset mid-operation returns everything to reset values immediately. A pending config and step are discarded.

Decomposition:
- Package vga_anim_pkg holds:
  - mode encodings MODE_STOP, MODE_RUN, MODE_STEP, MODE_AUTO.
  - A shared 2-bit mode type.
  - Default parameter constants.
- One sub-module, vga_frame_tick: vsync synchroniser and rising-edge pulse generator, also reusable by other frame-locked blocks.

Test Plan:
- Reset with vsync held high, then release -> frame_tick stays 0 until vsync falls and rises again; x_offset = 0; cfg_ready = 1.
- RUN, speed = 3, dir = 0, start 0x3FE, one tick -> x_offset = 0x001 (wrap). With dir = 1 from 0x001, speed 3 -> 0x3FE.
- Offer config (RUN, speed 5) mid-frame -> cfg_ready falls next cycle; offset unchanged at the first tick after accept; advances by 5 from the second tick. cfg_valid in the tick cycle is applied one tick later.
- STEP, speed 2: pulse step_req three times within one frame -> exactly one advance of 2 at the next tick and none at the following tick. step_req issued in STOP -> no advance.
- AUTO, HOLD_FRAMES = 3, NUM_PATTERNS = 4, 12 ticks -> pattern_sel sequence 0,0,0,1,1,1,2,2,2,3,3,3 then 0 on the 13th tick.
- Assert reset during AUTO with a pending config -> all outputs return to reset values asynchronously; the pending config is never applied after release.
